// File: rtl/pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// pll_phase_ctrl
//
// Sequences dynamic phase shifting of the ALTPLL. Decoded phase commands from
// the UDP command path (step-down, step-up, set absolute, reset to zero) are
// turned into a series of phasestep pulses with a fixed phaseupdown
// direction. Each step waits for the PLL's phasedone flag before the next one
// starts. The controller tracks the signed current phase offset
// (1 step = 4.5 deg).
//
// Parameters
//   STEP_PULSE    cycles phasestep is held high per step (1..255)
//   SETTLE        cycles after phasestep falls before phasedone is trusted
//   DONE_TIMEOUT  max cycles spent waiting on phasedone before abort (>=1)
//
// Ports
//   rx_clock     in   sole clock, all logic on posedge
//   n_reset      in   asynchronous active-low reset
//   cmd_valid    in   command present
//   cmd_ready    out  high only while idle; accept = cmd_valid & cmd_ready
//   cmd[1:0]     in   0 step-down, 1 step-up, 2 set absolute, 3 reset to 0
//   cmd_value    in   signed target for the set command, ignored otherwise
//   phasedone    in   PLL step-complete flag (level, active high)
//   phasestep    out  PLL step strobe
//   phaseupdown  out  1 = up, 0 = down; held for the whole command
//   phaseval     out  signed current phase offset, -128..127
//   busy         out  controller is not idle
//   cmd_done     out  1-cycle pulse on the first idle cycle after a command
//   timeout_err  out  sticky, set when phasedone never arrives
//   clear_err    in   clears timeout_err; a simultaneous set wins
//   abort        in   only with PLL_PHASE_ABORT_EN defined
//
// Configuration macro
//   PLL_PHASE_ABORT_EN  adds the abort input. Abort before the first step
//                       drops the command; abort during a step lets that
//                       step finish so phaseval stays consistent with the PLL.
// ---------------------------------------------------------------------------
module pll_phase_ctrl #(
    parameter int STEP_PULSE   = 5,
    parameter int SETTLE       = 2,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic              rx_clock,
    input  logic              n_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [7:0]        cmd_value,
    input  logic              phasedone,
    output logic              phasestep,
    output logic              phaseupdown,
    output logic signed [7:0] phaseval,
    output logic              busy,
    output logic              cmd_done,
    output logic              timeout_err,
    input  logic              clear_err
`ifdef PLL_PHASE_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int SEQ_MAX = (STEP_PULSE > SETTLE) ? STEP_PULSE : SETTLE;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int TO_W    = $clog2(DONE_TIMEOUT + 1);

    localparam logic [1:0] CMD_DOWN = 2'd0;
    localparam logic [1:0] CMD_UP   = 2'd1;
    localparam logic [1:0] CMD_SET  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ASSERT,
        S_SETTLE,
        S_WAIT_DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [1:0]               cmd_q;
    logic signed [7:0]        value_q;
    logic [7:0]               remaining;
    logic [SEQ_W-1:0]         seq_cnt;
    logic [TO_W-1:0]          to_cnt;

    logic                     abort_i;
    logic                     accept;
    logic signed [8:0]        phaseval_x;
    logic signed [8:0]        target;
    logic signed [8:0]        diff;
    logic                     no_step;
    logic [7:0]               rem_eff;
    logic                     step_ok;
    logic                     to_hit;
    logic                     pulse_last;
    logic                     settle_last;

`ifdef PLL_PHASE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Target offset for a command, computed one bit wider than phaseval so
    // that step-up at 127 and step-down at -128 are visible as out of range.
    function automatic logic signed [8:0] target_of(
        input logic [1:0]        c,
        input logic signed [8:0] cur,
        input logic signed [7:0] val
    );
        logic signed [8:0] t;
        case (c)
            CMD_DOWN: t = cur - 9'sd1;
            CMD_UP:   t = cur + 9'sd1;
            CMD_SET:  t = {val[7], val};
            default:  t = 9'sd0;
        endcase
        return t;
    endfunction

    function automatic logic in_range8(input logic signed [8:0] t);
        return (t >= -9'sd128) && (t <= 9'sd127);
    endfunction

    // |d| for d in -255..255 always fits in 8 unsigned bits.
    function automatic logic [7:0] mag8(input logic signed [8:0] d);
        logic signed [8:0] a;
        a = d[8] ? -d : d;
        return a[7:0];
    endfunction

    assign accept     = cmd_valid && cmd_ready;
    assign phaseval_x = {phaseval[7], phaseval};
    assign target     = target_of(cmd_q, phaseval_x, value_q);
    assign diff       = target - phaseval_x;
    assign no_step    = !in_range8(target) || (diff == 9'sd0);

    // An abort shortens the command to the step already in flight.
    assign rem_eff     = abort_i ? 8'd1 : remaining;
    assign step_ok     = (state == S_WAIT_DONE) && phasedone;
    assign to_hit      = (state == S_WAIT_DONE) && !phasedone &&
                         (to_cnt == TO_W'(DONE_TIMEOUT - 1));
    assign pulse_last  = (seq_cnt == SEQ_W'(STEP_PULSE - 1));
    assign settle_last = (seq_cnt == SEQ_W'(SETTLE - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (abort_i || no_step) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (pulse_last) begin
                    state_next = (SETTLE == 0) ? S_WAIT_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_last) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (phasedone) begin
                    state_next = (rem_eff == 8'd1) ? S_IDLE : S_ASSERT;
                end else if (to_hit) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control state and registered outputs. Outputs are decoded from the
    // next state so they are glitch-free and line up with the state register.
    always_ff @(posedge rx_clock or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            seq_cnt     <= '0;
            to_cnt      <= '0;
            phasestep   <= 1'b0;
            phaseupdown <= 1'b0;
            phaseval    <= 8'sd0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b0;
            cmd_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_next;
            seq_cnt   <= (state_next != state) ? '0 : seq_cnt + 1'b1;
            to_cnt    <= (state == S_WAIT_DONE) ? to_cnt + 1'b1 : '0;
            phasestep <= (state_next == S_ASSERT);
            busy      <= (state_next != S_IDLE);
            cmd_ready <= (state_next == S_IDLE);
            cmd_done  <= (state != S_IDLE) && (state_next == S_IDLE);

            if (state == S_CALC) begin
                phaseupdown <= (diff > 9'sd0);
            end

            // A timed-out step is not counted: the PLL state is unknown.
            if (step_ok) begin
                phaseval <= phaseupdown ? phaseval + 8'sd1 : phaseval - 8'sd1;
            end

            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // Command latch and step counter; always written before being used.
    always_ff @(posedge rx_clock) begin
        if (accept) begin
            cmd_q   <= cmd;
            value_q <= cmd_value;
        end
        case (state)
            S_CALC: begin
                remaining <= mag8(diff);
            end
            S_ASSERT, S_SETTLE, S_WAIT_DONE: begin
                if (step_ok) begin
                    remaining <= rem_eff - 8'd1;
                end else if (abort_i) begin
                    remaining <= 8'd1;
                end
            end
            default: begin
                remaining <= remaining;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_phase_ctrl
//
// Directed bench for pll_phase_ctrl (default build, no abort port). Each
// command is issued through run_cmd, which watches the step pulses, the
// direction during pulses and the busy/ready relation until cmd_done.
// Expected values are hand-derived: a command of n steps with phasedone
// already high ends with cmd_done 2 + n*(STEP_PULSE+SETTLE+1) samples after
// the accepting edge; a no-step command ends after 2 samples.
// ---------------------------------------------------------------------------
module tb_pll_phase_ctrl;

    logic       rx_clock;
    logic       n_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] cmd_value;
    logic       phasedone;
    logic       phasestep;
    logic       phaseupdown;
    logic [7:0] phaseval;
    logic       busy;
    logic       cmd_done;
    logic       timeout_err;
    logic       clear_err;

    int n_total = 0;
    int n_bad   = 0;

    pll_phase_ctrl #(
        .STEP_PULSE  (5),
        .SETTLE      (2),
        .DONE_TIMEOUT(1024)
    ) dut (
        .rx_clock   (rx_clock),
        .n_reset    (n_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cmd_value  (cmd_value),
        .phasedone  (phasedone),
        .phasestep  (phasestep),
        .phaseupdown(phaseupdown),
        .phaseval   (phaseval),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .timeout_err(timeout_err),
        .clear_err  (clear_err)
    );

    initial rx_clock = 1'b0;
    always #5 rx_clock = ~rx_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command at a negedge and monitor until cmd_done or budget.
    task automatic run_cmd(
        input  logic [1:0] c,
        input  logic [7:0] v,
        input  bit         hold,
        input  logic       exp_dir,
        input  int         budget,
        output int         cyc,
        output int         hi,
        output int         pulses,
        output int         bad
    );
        logic prev;
        bit   done;
        cyc = 0; hi = 0; pulses = 0; bad = 0; prev = 1'b0; done = 0;
        @(negedge rx_clock);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd       = c;
        cmd_value = v;
        cmd_valid = 1'b1;
        while (!done && cyc < budget) begin
            @(negedge rx_clock);
            cyc++;
            if (!hold) cmd_valid = 1'b0;
            if (phasestep) hi++;
            if (phasestep && !prev) pulses++;
            prev = phasestep;
            if (phasestep && (phaseupdown !== exp_dir)) bad++;
            if (busy === cmd_ready) bad++;
            if (cmd_done) done = 1;
        end
        cmd_valid = 1'b0;
        chk("cmd_done_seen", done, 1);
    endtask

    int cyc, hi, pulses, bad;

    initial begin
        n_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        cmd_value = 8'd0;
        phasedone = 1'b1;
        clear_err = 1'b0;

        // reset state
        repeat (2) @(negedge rx_clock);
        chk("reset_outputs", {cmd_ready, phasestep, phaseupdown, busy, cmd_done,
                              timeout_err, phaseval}, 0);
        n_reset = 1'b1;
        @(negedge rx_clock);
        chk("ready_after_reset", cmd_ready, 1);
        chk("busy_after_reset", busy, 0);

        // single step-up, cmd_valid held through busy (must not re-accept)
        run_cmd(2'd1, 8'd0, 1, 1'b1, 100, cyc, hi, pulses, bad);
        chk("up1_latency", cyc, 10);
        chk("up1_step_hi", hi, 5);
        chk("up1_pulses", pulses, 1);
        chk("up1_dir_ready", bad, 0);
        chk("up1_updown", phaseupdown, 1);
        chk("up1_val", phaseval, 8'h01);
        repeat (3) @(negedge rx_clock);
        chk("up1_no_reaccept", {busy, phaseval}, {1'b0, 8'h01});

        run_cmd(2'd1, 8'd0, 0, 1'b1, 100, cyc, hi, pulses, bad);
        chk("up2_val", phaseval, 8'h02);

        // set -3 from 2: five down-steps
        run_cmd(2'd2, 8'hFD, 0, 1'b0, 200, cyc, hi, pulses, bad);
        chk("set_m3_latency", cyc, 42);
        chk("set_m3_pulses", pulses, 5);
        chk("set_m3_step_hi", hi, 25);
        chk("set_m3_dir_ready", bad, 0);
        chk("set_m3_updown", phaseupdown, 0);
        chk("set_m3_val", phaseval, 8'hFD);

        run_cmd(2'd0, 8'h55, 0, 1'b0, 100, cyc, hi, pulses, bad);
        chk("down_latency", cyc, 10);
        chk("down_val", phaseval, 8'hFC);

        // to +127 (131 up-steps), then step-up at the top is refused
        run_cmd(2'd2, 8'h7F, 0, 1'b1, 1200, cyc, hi, pulses, bad);
        chk("set_127_pulses", pulses, 131);
        chk("set_127_latency", cyc, 1050);
        chk("set_127_val", phaseval, 8'h7F);
        run_cmd(2'd1, 8'd0, 0, 1'b1, 50, cyc, hi, pulses, bad);
        chk("up_at_max_latency", cyc, 2);
        chk("up_at_max_pulses", pulses, 0);
        chk("up_at_max_val", phaseval, 8'h7F);

        // to -128 (255 down-steps), then step-down at the bottom is refused
        run_cmd(2'd2, 8'h80, 0, 1'b0, 2200, cyc, hi, pulses, bad);
        chk("set_m128_pulses", pulses, 255);
        chk("set_m128_val", phaseval, 8'h80);
        run_cmd(2'd0, 8'd0, 0, 1'b0, 50, cyc, hi, pulses, bad);
        chk("down_at_min_latency", cyc, 2);
        chk("down_at_min_pulses", pulses, 0);
        chk("down_at_min_val", phaseval, 8'h80);

        // reset-to-zero from -128: 128 up-steps
        run_cmd(2'd3, 8'h99, 0, 1'b1, 1200, cyc, hi, pulses, bad);
        chk("zero_pulses", pulses, 128);
        chk("zero_latency", cyc, 1026);
        chk("zero_dir_ready", bad, 0);
        chk("zero_updown", phaseupdown, 1);
        chk("zero_val", phaseval, 8'h00);

        // set to current value: nothing to do
        run_cmd(2'd2, 8'h00, 0, 1'b0, 50, cyc, hi, pulses, bad);
        chk("set_same_latency", cyc, 2);
        chk("set_same_pulses", pulses, 0);

        // phasedone never arrives: timeout after 1024 waiting cycles
        phasedone = 1'b0;
        run_cmd(2'd1, 8'd0, 0, 1'b1, 1200, cyc, hi, pulses, bad);
        chk("to_latency", cyc, 1033);
        chk("to_pulses", pulses, 1);
        chk("to_err_set", timeout_err, 1);
        chk("to_val_kept", phaseval, 8'h00);
        repeat (3) @(negedge rx_clock);
        chk("to_err_sticky", timeout_err, 1);
        clear_err = 1'b1;
        @(negedge rx_clock);
        clear_err = 1'b0;
        chk("to_err_cleared", timeout_err, 0);
        phasedone = 1'b1;

        // async reset during step 3 of a 5-step set
        begin
            logic prev;
            bit   found;
            prev   = 1'b0;
            found  = 0;
            pulses = 0;
            @(negedge rx_clock);
            cmd       = 2'd2;
            cmd_value = 8'd5;
            cmd_valid = 1'b1;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge rx_clock);
                cmd_valid = 1'b0;
                if (phasestep && !prev) pulses++;
                prev = phasestep;
                if (pulses == 3) found = 1;
            end
            chk("rst_mid_reached", found, 1);
            chk("rst_mid_val_before", phaseval, 8'h02);
            #2 n_reset = 1'b0;
            #1 chk("rst_mid_outputs", {cmd_ready, phasestep, phaseupdown, busy,
                                       cmd_done, timeout_err, phaseval}, 0);
            @(posedge rx_clock);
            @(negedge rx_clock);
            n_reset = 1'b1;
            @(negedge rx_clock);
            chk("rst_mid_ready", cmd_ready, 1);
            chk("rst_mid_val", phaseval, 8'h00);
        end

        run_cmd(2'd1, 8'd0, 0, 1'b1, 100, cyc, hi, pulses, bad);
        chk("post_rst_up_val", phaseval, 8'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
